fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction-fetch stage of the ARM pipeline. It holds the program counter, drives the word address into the instruction memory, and captures the returned instruction into the IF/ID pipeline register. It handles hazard freeze, taken-branch redirect and flush, and counts frozen cycles for performance measurement. It sits directly upstream of decode and drives the instruction memory's pc input.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
NOP_INSTR, 32'h0000_0000, instruction injected into IF/ID on flush or reset.
CNT_W, 16, width of the freeze-cycle counter.

Ports:
clk  input  1  rising-edge clock for all state
rst  input  1  synchronous, active-high reset
freeze  input  1  hazard stall from the hazard unit: hold PC and IF/ID
branch_taken  input  1  redirect from EXE: load branch_addr into PC, flush IF/ID
branch_addr  input  32  branch target byte address
flush  input  1  explicit IF/ID flush without PC redirect
imem_pc  output  32  current PC to the instruction memory (combinational copy of the PC register)
imem_instr  input  32  instruction returned combinationally by the instruction memory for imem_pc
if_pc  output  32  registered PC+4 of the captured instruction
if_instr  output  32  registered instruction
if_valid  output  1  1 = if_instr is a real fetched instruction
freeze_cnt  output  CNT_W  saturating count of cycles with freeze=1 and branch_taken=0

Behaviour:
- Reset, while rst=1 at a clk edge: PC<=RESET_PC; if_pc<=0; if_instr<=NOP_INSTR; if_valid<=0; freeze_cnt<=0. Reset overrides every other input, including mid-freeze and a same-cycle branch.
- imem_pc = PC register, with no added latency. imem_instr is sampled in the same cycle.
- PC update at each edge, in priority order:
  - branch_taken: PC<={branch_addr[31:2],2'b00}. Low address bits are silently dropped.
  - freeze: PC holds.
  - otherwise: PC<=PC+4, modulo 2^32. 32'hFFFF_FFFC wraps to 0.
- IF/ID update at each edge, in priority order:
  - branch_taken or flush: if_instr<=NOP_INSTR; if_valid<=0; if_pc<=0.
  - freeze: all IF/ID outputs hold.
  - otherwise: if_pc<=PC+4; if_instr<=imem_instr; if_valid<=1.
- Simultaneous events:
  - branch_taken with freeze: the branch wins and the freeze is ignored that cycle. The PC redirects and IF/ID flushes.
  - flush with freeze, no branch: the PC holds and IF/ID flushes.
- Latency: an instruction at address A appears on if_instr exactly one edge after imem_pc==A with freeze=0. After a taken branch there is one bubble (if_valid=0), then the target instruction on the following edge.
- First cycle after reset deasserts: imem_pc=RESET_PC and if_valid=0. The first valid instruction appears after the next edge.
- freeze_cnt:
  - Increments by 1 on each edge with freeze=1, branch_taken=0, rst=0.
  - Saturates at 2^CNT_W-1 and never wraps.
- No other state machine; the block is a pipelined register stage.

Decomposition:
- Shared pipeline package holds:
  - NOP_INSTR and RESET_PC constants.
  - An if_id_t struct {pc[31:0], instr[31:0], valid} so decode consumes the same type.
- One natural sub-module, if_id_reg:
  - Registers with synchronous clear (flush) and hold (freeze) enables.
  - Reused for the later ID/EX and EX/MEM registers.
- The PC register, the +4 adder and the saturating counter stay in fetch_stage.

Test Plan:
- Reset then 4 free-running cycles, with the memory model returning 0x1000_0000+addr: imem_pc goes 0,4,8,12. if_instr lags by one edge (0x1000_0000, 0x1000_0004, ...), if_pc = 4,8,12, if_valid=0 then 1.
- freeze=1 for 3 cycles at PC=8: imem_pc stays 8, if_instr/if_pc/if_valid hold, freeze_cnt goes 0->3. After release, the fetch resumes at 8 then 12.
- branch_taken=1 with branch_addr=0x0000_0043 at PC=12: next imem_pc=0x40, if_valid=0, if_instr=NOP_INSTR. The edge after that gives if_instr=mem[0x40] and if_pc=0x44.
- branch_taken=1 and freeze=1 in the same cycle: the branch is taken (PC=branch_addr aligned), IF/ID is flushed, and freeze_cnt does not increment.
- Force PC to 0xFFFF_FFFC via branch, then run 1 free cycle: imem_pc=0 and if_pc=0.
- rst=1 asserted mid-freeze with freeze_cnt=5: after one edge PC=RESET_PC, if_valid=0, freeze_cnt=0. A CNT_W=2 build frozen for 6 cycles holds freeze_cnt at 3.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions: fetch defaults and the IF/ID register payload
// that decode consumes.
package fetch_stage_pkg;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
  } if_id_t;

  localparam int IF_ID_W = $bits(if_id_t);

  // Instruction addresses are word addresses; the byte-offset bits are discarded.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// Generic pipeline register with synchronous clear and hold enables.
// Clear has priority over hold, so a flush during a stall still empties the stage.
module if_id_reg #(
  parameter int           W       = 1,
  parameter logic [W-1:0] CLR_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         hold,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = CLR_VAL;
    end else if (!hold) begin
      q_d = d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= CLR_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, +4 adder, IF/ID capture and a
// saturating counter of cycles lost to hazard freeze.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = fetch_stage_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR = fetch_stage_pkg::NOP_INSTR,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             branch_taken,
  input  logic [31:0]      branch_addr,
  input  logic             flush,
  output logic [31:0]      imem_pc,
  input  logic [31:0]      imem_instr,
  output logic [31:0]      if_pc,
  output logic [31:0]      if_instr,
  output logic             if_valid,
  output logic [CNT_W-1:0] freeze_cnt
);

  import fetch_stage_pkg::*;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam if_id_t           IF_ID_CLR = '{pc: 32'd0, instr: NOP_INSTR, valid: 1'b0};

  logic [31:0]      pc_q;
  logic [31:0]      pc_d;
  logic [31:0]      pc_plus4;
  logic [CNT_W-1:0] freeze_cnt_q;
  logic [CNT_W-1:0] freeze_cnt_d;
  logic             if_id_clr;
  if_id_t           if_id_d;
  if_id_t           if_id_q;

  always_comb pc_plus4 = pc_q + 32'd4;

  // A taken branch beats freeze: the stalled instruction is on the wrong path anyway.
  always_comb begin
    pc_d = pc_q;
    if (branch_taken) begin
      pc_d = word_align(branch_addr);
    end else if (!freeze) begin
      pc_d = pc_plus4;
    end
  end

  always_comb begin
    freeze_cnt_d = freeze_cnt_q;
    if (freeze && !branch_taken && (freeze_cnt_q != CNT_MAX)) begin
      freeze_cnt_d = freeze_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      freeze_cnt_q <= '0;
    end else begin
      pc_q         <= pc_d;
      freeze_cnt_q <= freeze_cnt_d;
    end
  end

  always_comb begin
    if_id_clr = branch_taken || flush;
    if_id_d   = '{pc: pc_plus4, instr: imem_instr, valid: 1'b1};
  end

  if_id_reg #(
    .W       (IF_ID_W),
    .CLR_VAL (IF_ID_CLR)
  ) u_if_id (
    .clk  (clk),
    .rst  (rst),
    .clr  (if_id_clr),
    .hold (freeze),
    .d    (if_id_d),
    .q    (if_id_q)
  );

  assign imem_pc    = pc_q;
  assign if_pc      = if_id_q.pc;
  assign if_instr   = if_id_q.instr;
  assign if_valid   = if_id_q.valid;
  assign freeze_cnt = freeze_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a behavioural model predicts the state after
// each edge; a monitor compares it with both a 16-bit and a 2-bit counter build.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam logic [31:0] MEM_BASE = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = 32'd0;
  logic        flush = 1'b0;

  logic [31:0] imem_pc, imem_instr, if_pc, if_instr;
  logic        if_valid;
  logic [15:0] freeze_cnt;

  logic [31:0] imem_pc2, imem_instr2, if_pc2, if_instr2;
  logic        if_valid2;
  logic [1:0]  freeze_cnt2;

  always #5 clk = ~clk;

  // Instruction memory: every word holds MEM_BASE plus its own address.
  assign imem_instr  = MEM_BASE + imem_pc;
  assign imem_instr2 = MEM_BASE + imem_pc2;

  fetch_stage #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
    .branch_addr(branch_addr), .flush(flush), .imem_pc(imem_pc),
    .imem_instr(imem_instr), .if_pc(if_pc), .if_instr(if_instr),
    .if_valid(if_valid), .freeze_cnt(freeze_cnt)
  );

  fetch_stage #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
    .branch_addr(branch_addr), .flush(flush), .imem_pc(imem_pc2),
    .imem_instr(imem_instr2), .if_pc(if_pc2), .if_instr(if_instr2),
    .if_valid(if_valid2), .freeze_cnt(freeze_cnt2)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ifpc;
    logic [31:0] instr;
    logic        valid;
    int          cnt;
    int          cnt2;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state (value after the most recent edge).
  logic [31:0] m_pc = 32'd0;
  logic [31:0] m_ifpc = 32'd0;
  logic [31:0] m_instr = NOP;
  logic        m_valid = 1'b0;
  int          m_cnt = 0;
  int          m_cnt2 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      chk("imem_pc",     imem_pc,    e.pc);
      chk("if_pc",       if_pc,      e.ifpc);
      chk("if_instr",    if_instr,   e.instr);
      chk("if_valid",    {31'd0, if_valid}, {31'd0, e.valid});
      chk("freeze_cnt",  {16'd0, freeze_cnt}, e.cnt);
      chk("freeze_cnt2", {30'd0, freeze_cnt2}, e.cnt2);
      chk("imem_pc2",    imem_pc2,   e.pc);
      chk("if_instr2",   if_instr2,  e.instr);
    end
  end

  // Apply one cycle of inputs, predict the resulting state from the rules, push it.
  task automatic step(input logic r, input logic f, input logic b,
                      input logic [31:0] a, input logic fl);
    exp_t e;
    @(negedge clk);
    rst = r; freeze = f; branch_taken = b; branch_addr = a; flush = fl;
    if (r) begin
      m_pc = 32'd0; m_ifpc = 32'd0; m_instr = NOP; m_valid = 1'b0;
      m_cnt = 0; m_cnt2 = 0;
    end else begin
      logic [31:0] fetched_addr;
      fetched_addr = m_pc;
      if (b || fl) begin
        m_ifpc = 32'd0; m_instr = NOP; m_valid = 1'b0;
      end else if (!f) begin
        m_ifpc = fetched_addr + 32'd4;
        m_instr = MEM_BASE + fetched_addr;
        m_valid = 1'b1;
      end
      if (b) m_pc = (a / 4) * 4;
      else if (!f) m_pc = fetched_addr + 32'd4;
      if (f && !b) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
      end
    end
    e.pc = m_pc; e.ifpc = m_ifpc; e.instr = m_instr; e.valid = m_valid;
    e.cnt = m_cnt; e.cnt2 = m_cnt2;
    sb_q.push_back(e);
    @(posedge clk);
  endtask

  initial begin
    step(1, 0, 0, 0, 0);
    step(1, 1, 1, 32'h55, 0);            // reset beats same-cycle branch and freeze
    repeat (4) step(0, 0, 0, 0, 0);      // free run from reset
    step(1, 0, 0, 0, 0);
    repeat (2) step(0, 0, 0, 0, 0);      // PC reaches 8
    repeat (3) step(0, 1, 0, 0, 0);      // freeze at PC 8
    repeat (2) step(0, 0, 0, 0, 0);
    step(0, 0, 1, 32'h0000_0043, 0);     // misaligned target
    repeat (2) step(0, 0, 0, 0, 0);
    step(0, 1, 1, 32'h0000_0200, 0);     // branch wins over freeze
    step(0, 1, 0, 0, 1);                 // flush while frozen
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 32'hFFFF_FFFE, 0);     // to top of address space
    repeat (2) step(0, 0, 0, 0, 0);      // wrap to 0
    repeat (6) step(0, 1, 0, 0, 0);      // 2-bit counter saturates
    step(1, 1, 0, 0, 0);                 // reset mid-freeze
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      logic r, f, b, fl;
      logic [31:0] a;
      r  = ($urandom_range(0, 99) < 2);
      f  = ($urandom_range(0, 99) < 35);
      b  = ($urandom_range(0, 99) < 10);
      fl = ($urandom_range(0, 99) < 10);
      a  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
      step(r, f, b, a, fl);
    end
    repeat (200) step(0, 1, 0, 0, 0);    // long stall on the 16-bit counter
    @(negedge clk);
    freeze = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries never compared, required 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
